// File: rtl/mux_scan_ctrl.sv
// Round-robin select sequencer for a 4:1 MUX: holds each enabled channel for a
// programmable dwell, samples the MUX output at the end of each dwell and emits 4-bit frames.
module mux_scan_ctrl #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               cont,
  input  logic [3:0]         ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               Y,
  output logic               S1,
  output logic               S2,
  output logic [3:0]         frame,
  output logic               frame_valid,
  output logic               busy
);

  typedef enum logic {ST_IDLE, ST_SCAN} state_t;

  localparam logic [DWELL_W-1:0] c_one = DWELL_W'(1);

  state_t             r_state;
  state_t             w_state_next;
  logic [3:0]         r_mask;
  logic [DWELL_W-1:0] r_dwell;
  logic [DWELL_W-1:0] r_cnt;
  logic [1:0]         r_sel;
  logic [3:0]         r_buf;
  logic [3:0]         r_frame;
  logic               r_frame_valid;

  logic [DWELL_W-1:0] w_dwell_in;
  logic [2:0]         w_first_in;
  logic [2:0]         w_next_ch;
  logic               w_dwell_done;
  logic               w_frame_end;
  logic               w_start_go;
  logic [3:0]         w_buf_upd;

  // Returns {found, index} of the lowest set bit of m at or above position from.
  function automatic logic [2:0] first_at_or_above(input logic [3:0] m, input logic [2:0] from);
    logic [2:0] res;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      if (m[k] && (k >= int'(from))) res = {1'b1, 2'(k)};
    end
    return res;
  endfunction

  assign w_dwell_in   = (dwell == '0) ? c_one : dwell;
  assign w_first_in   = first_at_or_above(ch_mask, 3'd0);
  assign w_next_ch    = first_at_or_above(r_mask, {1'b0, r_sel} + 3'd1);
  assign w_start_go   = (r_state == ST_IDLE) && start;
  assign w_dwell_done = (r_state == ST_SCAN) && (r_cnt <= c_one);
  assign w_frame_end  = w_dwell_done && !w_next_ch[2];
  assign w_buf_upd    = r_buf | ({3'b000, Y} << r_sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start && (ch_mask != 4'b0000)) w_state_next = ST_SCAN;
      end
      ST_SCAN: begin
        if (w_frame_end) begin
          w_state_next = (cont && (ch_mask != 4'b0000)) ? ST_SCAN : ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask        <= '0;
      r_dwell       <= '0;
      r_cnt         <= '0;
      r_sel         <= '0;
      r_buf         <= '0;
      r_frame       <= '0;
      r_frame_valid <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      if (w_start_go) begin
        r_mask  <= ch_mask;
        r_dwell <= w_dwell_in;
        r_cnt   <= w_dwell_in;
        r_sel   <= w_first_in[1:0];
        r_buf   <= '0;
        if (ch_mask == 4'b0000) begin
          r_frame       <= '0;
          r_frame_valid <= 1'b1;
        end
      end else if (r_state == ST_SCAN) begin
        if (w_dwell_done) begin
          if (w_next_ch[2]) begin
            r_buf <= w_buf_upd;
            r_sel <= w_next_ch[1:0];
            r_cnt <= r_dwell;
          end else begin
            r_frame       <= w_buf_upd & r_mask;
            r_frame_valid <= 1'b1;
            r_buf         <= '0;
            // Continuous mode picks up the live mask/dwell for the back-to-back frame.
            if (cont) begin
              r_mask  <= ch_mask;
              r_dwell <= w_dwell_in;
              r_cnt   <= w_dwell_in;
              r_sel   <= w_first_in[1:0];
            end
          end
        end else begin
          r_cnt <= r_cnt - c_one;
        end
      end
    end
  end

  assign {S1, S2}    = (r_state == ST_SCAN) ? r_sel : 2'b00;
  assign busy        = (r_state == ST_SCAN);
  assign frame       = r_frame;
  assign frame_valid = r_frame_valid;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: a 4:1 MUX model feeds Y, a schedule model
// derived from mask/dwell predicts select, busy, frame and frame_valid every cycle.
module tb_mux_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       cont;
  logic [3:0] ch_mask;
  logic [7:0] dwell;
  logic       y;
  logic       s1;
  logic       s2;
  logic [3:0] frame;
  logic       frame_valid;
  logic       busy;

  logic [3:0] ivec;
  logic [3:0] exp_hold;
  int         n_chk;
  int         n_fail;

  typedef struct {
    logic [3:0] mask;
    logic [7:0] dwl;
    logic [3:0] iv;
    logic [3:0] exp_frame;
    int         exp_lat;
  } vec_t;

  vec_t vecs[8];

  mux_scan_ctrl #(.DWELL_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cont        (cont),
    .ch_mask     (ch_mask),
    .dwell       (dwell),
    .Y           (y),
    .S1          (s1),
    .S2          (s2),
    .frame       (frame),
    .frame_valid (frame_valid),
    .busy        (busy)
  );

  assign y = ivec[{s1, s2}];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cycle(input string tag, input int c, input int e_sel, input int e_busy,
                           input int e_fv);
    chk($sformatf("%s c%0d sel", tag, c), int'({s1, s2}), e_sel);
    chk($sformatf("%s c%0d busy", tag, c), int'(busy), e_busy);
    chk($sformatf("%s c%0d valid", tag, c), int'(frame_valid), e_fv);
    chk($sformatf("%s c%0d frame", tag, c), int'(frame), int'(exp_hold));
  endtask

  function automatic int model_lat(input logic [3:0] m, input logic [7:0] d);
    int dd;
    dd = (d == 8'd0) ? 1 : int'(d);
    return 1 + $countones(m) * dd;
  endfunction

  // Single non-continuous frame; called at #1 after an edge with the DUT idle.
  task automatic run_frame(input string tag, input logic [3:0] m, input logic [7:0] d,
                           input logic [3:0] iv, input logic [3:0] e_frame, input int e_lat,
                           input bit noise);
    int dd;
    int chans[$];
    int e_sel;
    dd = (d == 8'd0) ? 1 : int'(d);
    for (int k = 0; k < 4; k++) if (m[k]) chans.push_back(k);
    ivec = iv; ch_mask = m; dwell = d; cont = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= e_lat; c++) begin
      if (c > 1) step();
      e_sel = 0;
      if (c < e_lat && (c - 1) / dd < chans.size()) e_sel = chans[(c - 1) / dd];
      if (c == e_lat) exp_hold = e_frame;
      chk_cycle(tag, c, e_sel, (c < e_lat) ? 1 : 0, (c == e_lat) ? 1 : 0);
      if (noise && c < e_lat) begin
        start = 1'($urandom); ch_mask = 4'($urandom); dwell = 8'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    $display("frame %s mask=%b dwell=%0d I=%b -> frame=%b lat=%0d", tag, m, d, iv, frame, e_lat);
  endtask

  initial begin
    int e_sel;
    int e_busy;
    int e_fv;
    logic [3:0] rm;
    logic [7:0] rd;
    logic [3:0] ri;

    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; start = 1'b0; cont = 1'b0; ch_mask = 4'b0; dwell = 8'd0; ivec = 4'b0;
    exp_hold = 4'b0;

    vecs[0] = '{4'b1111, 8'd2,   4'b1010, 4'b1010, 9};
    vecs[1] = '{4'b0101, 8'd1,   4'b1111, 4'b0101, 3};
    vecs[2] = '{4'b1000, 8'd0,   4'b1000, 4'b1000, 2};
    vecs[3] = '{4'b0000, 8'd0,   4'b1111, 4'b0000, 1};
    vecs[4] = '{4'b0110, 8'd3,   4'b0100, 4'b0100, 7};
    vecs[5] = '{4'b1001, 8'd1,   4'b1111, 4'b1001, 3};
    vecs[6] = '{4'b0010, 8'd255, 4'b0010, 4'b0010, 256};
    vecs[7] = '{4'b1111, 8'd1,   4'b0000, 4'b0000, 5};

    #1;
    chk_cycle("reset", 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    chk_cycle("idle", 0, 0, 0, 0);

    for (int i = 0; i < 8; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].mask, vecs[i].dwl, vecs[i].iv,
                vecs[i].exp_frame, vecs[i].exp_lat, 1'b0);
    end

    // Continuous mode: two back-to-back frames 6 cycles apart, cont dropped during the second.
    ivec = 4'b0001; ch_mask = 4'b0011; dwell = 8'd3; cont = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      if (c > 1) step();
      e_sel  = (c < 13) ? (((c - 1) % 6) / 3) : 0;
      e_busy = (c < 13) ? 1 : 0;
      e_fv   = (c == 7 || c == 13) ? 1 : 0;
      if (c == 7) exp_hold = 4'b0001;
      if (c == 13) exp_hold = 4'b0010;
      chk_cycle("cont", c, e_sel, e_busy, e_fv);
      if (c == 7) ivec = 4'b0010;
      if (c == 8) cont = 1'b0;
    end
    $display("frame cont pair -> last frame=%b busy=%b", frame, busy);

    // Continuous mode whose re-latched mask is empty must fall back to idle.
    ivec = 4'b0010; ch_mask = 4'b0010; dwell = 8'd1; cont = 1'b1; start = 1'b1;
    step();
    start = 1'b0; ch_mask = 4'b0000;
    chk_cycle("cont0", 1, 1, 1, 0);
    step();
    exp_hold = 4'b0010;
    chk_cycle("cont0", 2, 0, 0, 1);
    cont = 1'b0;
    step();
    chk_cycle("cont0", 3, 0, 0, 0);
    $display("frame cont0 -> frame=%b busy=%b", frame, busy);

    // Reset during the second channel: outputs clear without waiting for a clock edge.
    ivec = 4'b1111; ch_mask = 4'b1111; dwell = 8'd2; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("rst pre sel", int'({s1, s2}), 1);
    #3 rst_n = 1'b0;
    #1;
    exp_hold = 4'b0000;
    chk_cycle("rst async", 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    step();
    chk_cycle("rst idle", 0, 0, 0, 0);
    run_frame("after_rst", 4'b1111, 8'd2, 4'b0101, 4'b0101, 9, 1'b0);

    for (int i = 0; i < 30; i++) begin
      rm = 4'($urandom);
      rd = 8'($urandom_range(0, 5));
      ri = 4'($urandom);
      run_frame($sformatf("rnd%0d", i), rm, rd, ri, ri & rm, model_lat(rm, rd), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Sequencer that sits directly upstream of the team's 4:1 MUX and drives its select pair {S1,S2}. It round-robin scans the enabled channels, holding each for a programmable dwell time.
- It consumes the MUX output Y and samples it at the end of each dwell. Each completed scan is assembled into a 4-bit frame, marked with a one-cycle valid pulse.
- Used for time-multiplexed monitoring of four single-bit signals through one MUX.

Parameters:
- DWELL_W, 8, width of the dwell count; dwell range is 1..2^DWELL_W-1 cycles.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begins a scan when sampled high in IDLE.
- cont  input  1  continuous mode; sampled at each frame end.
- ch_mask  input  4  channel enable; bit k enables channel k.
- dwell  input  DWELL_W  cycles each channel is held selected.
- Y  input  1  MUX output for the currently selected channel.
- S1  output  1  select MSB to the MUX.
- S2  output  1  select LSB to the MUX.
- frame  output  4  last completed frame; bit k = sample of channel k, 0 if channel k is masked.
- frame_valid  output  1  one-cycle pulse when frame updates.
- busy  output  1  high while scanning.

Behaviour:
- Reset (async assert, sync release): state IDLE; S1=S2=0; frame=0; frame_valid=0; busy=0; internal buffer, counters and latched mask/dwell cleared. Reset mid-scan discards the partial frame.
- Select mapping: {S1,S2} = channel index (00→ch0 … 11→ch3). Channels are visited in ascending order, skipping masked ones.
- States:
  - IDLE: S1/S2 = 00, busy=0.
  - SCAN: select = current channel, busy=1.
- Start: start=1 in IDLE at edge t latches ch_mask→m and D = (dwell==0 ? 1 : dwell). start while busy is ignored. ch_mask/dwell changes mid-frame have no effect.
- Empty mask: if m==0 at start, stay IDLE. frame←0, frame_valid=1 in cycle t+1.
- First channel: otherwise enter SCAN. From cycle t+1, select = lowest enabled channel and the dwell counter is loaded.
- Dwell and sampling: each channel is held exactly D cycles. Y is captured into buffer bit k at the edge ending the D-th cycle. The select moves to the next enabled channel in the following cycle; there are no gap cycles.
- Frame completion: at the edge sampling the last enabled channel:
  - frame ← buffer with masked bits forced to 0; buffer cleared.
  - frame_valid high for exactly the next cycle.
  - Latency: frame_valid is asserted in cycle t+1+N*D, where N = popcount(m).
- Frame end, cont=1: re-latch ch_mask/dwell at that same edge. If the new mask ≠ 0, the next frame's first channel is selected in the cycle frame_valid is high (back-to-back frames, busy stays 1).
- Frame end, cont=1, new mask = 0: go to IDLE.
- Frame end, cont=0: go to IDLE; S1/S2 return to 00, busy=0. A start in the cycle frame_valid is high is accepted (state is already IDLE).
- Counter: down-counter, DWELL_W bits, never wraps.
- Buffer bits of unvisited channels stay 0.
- frame holds its value between pulses.

Test Plan:
- Full scan: mask=1111, dwell=2, MUX model with I=4'b1010, start at edge t → select 00,00,01,01,10,10,11,11 over cycles t+1..t+8; frame=1010, frame_valid=1 only in cycle t+9; busy drops the same cycle.
- Sparse mask: mask=0101, dwell=1, I=4'b1111 → select 00 then 10; frame=0101, frame_valid at t+3; channels 1 and 3 never selected.
- Dwell zero and empty mask: dwell=0, mask=1000, I=4'b1000 → select 11 for one cycle, frame=1000 at t+2. Then mask=0000 with start → no select change, frame=0000, frame_valid at next cycle.
- Continuous mode: cont=1, mask=0011, dwell=3, I changes from 0001 to 0010 between frames → consecutive frames 0001 then 0010, pulses 6 cycles apart, busy stays 1. Dropping cont before the second frame ends → IDLE afterward.
- Ignore and hold: start pulsed mid-scan and ch_mask/dwell changed mid-frame → frame timing and content unaffected.
- Reset mid-scan: rst_n low during the 2nd channel → all outputs 0 immediately (asynchronously). After release, a new start yields a correct full frame with no residue from the aborted one.
